// File: rtl/rps_throw_gen.sv
// rps_throw_gen: debounced play button draws an LFSR-based rock/paper/scissors throw.
module rps_throw_gen #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       playButton,
    output logic [2:0] p2Throw,
    output logic [1:0] p2Dense,
    output logic       throwValid,
    output logic [3:0] roundCount,
    output logic [7:0] lfsrState
);
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, DRAW, SHOW} state_t;
    state_t state;
    logic sync1, sync2, db_level, db_level_prev, db_rise;
    logic [CW-1:0] db_count;
    assign db_rise = db_level & ~db_level_prev;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsrState <= SEED;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db_level <= 1'b0;
            db_level_prev <= 1'b0;
            db_count <= '0;
        end else begin
            lfsrState <= {lfsrState[6:0], lfsrState[7] ^ lfsrState[5] ^ lfsrState[4] ^ lfsrState[3]};
            sync1 <= playButton;
            sync2 <= sync1;
            db_level_prev <= db_level;
            if (sync2 == db_level) begin
                db_count <= '0;
            end else if (db_count == DB_MAX) begin
                db_level <= sync2;
                db_count <= '0;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end
    // Code 3 is rejected in DRAW; the free-running LFSR supplies a fresh value next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            p2Throw <= 3'b000;
            p2Dense <= 2'd3;
            throwValid <= 1'b0;
            roundCount <= 4'd0;
        end else begin
            throwValid <= 1'b0;
            case (state)
                IDLE: if (db_rise) state <= DRAW;
                DRAW: if (lfsrState[1:0] != 2'd3) begin
                    p2Dense <= lfsrState[1:0];
                    p2Throw <= 3'b001 << lfsrState[1:0];
                    roundCount <= roundCount + 4'd1;
                    throwValid <= 1'b1;
                    state <= SHOW;
                end
                SHOW: if (!db_level) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rps_throw_gen.sv
// tb_rps_throw_gen: scoreboard bench; predicted throws are queued at press time and matched on throwValid.
module tb_rps_throw_gen;
    localparam int N = 4;
    localparam logic [7:0] SEED = 8'hA5;
    logic clk = 1'b0, reset = 1'b1, playButton = 1'b0;
    logic [2:0] p2Throw;
    logic [1:0] p2Dense;
    logic throwValid;
    logic [3:0] roundCount;
    logic [7:0] lfsrState;
    typedef struct {
        logic [1:0] d;
        logic [3:0] r;
        int c;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;
    int tests = 0, fails = 0, cyc = 0, npulse = 0;
    logic [7:0] m_lfsr;
    logic [3:0] exp_round = 4'd0;
    logic [2:0] seen = 3'b000, mask = 3'b000;
    logic [7:0] lfsr_exp [4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};

    rps_throw_gen #(.LFSR_SEED(SEED), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .playButton(playButton), .p2Throw(p2Throw), .p2Dense(p2Dense),
        .throwValid(throwValid), .roundCount(roundCount), .lfsrState(lfsrState)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else m_lfsr <= adv(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge 0 is the next posedge; DRAW samples the value after N+3 advances, skipping code 3.
    task automatic predict(input logic [7:0] cur, output int r, output logic [1:0] d);
        logic [7:0] v = cur;
        for (int k = 0; k < N + 3; k++) v = adv(v);
        r = 0;
        while (v[1:0] == 2'd3 && r < 300) begin
            v = adv(v);
            r++;
        end
        d = v[1:0];
    endtask

    task automatic expect_throw();
        int r;
        logic [1:0] d;
        exp_t e;
        predict(m_lfsr, r, d);
        exp_round = exp_round + 4'd1;
        e.d = d;
        e.r = exp_round;
        e.c = cyc + 1 + N + 3 + r;
        sb.push_back(e);
        mask = mask | (3'b001 << d);
    endtask

    task automatic press(input int hold);
        expect_throw();
        playButton = 1'b1;
        repeat (hold) @(negedge clk);
        playButton = 1'b0;
        repeat (N + 8) @(negedge clk);
        check("throw_arrived", sb.size(), 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_round = 4'd0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (throwValid) begin
            npulse++;
            seen = seen | p2Throw;
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e_m = sb.pop_front();
                check("dense", p2Dense, e_m.d);
                check("onehot", p2Throw, 3'b001 << e_m.d);
                check("round", roundCount, e_m.r);
                check("valid_cycle", cyc, e_m.c);
            end
        end
    end

    initial begin
        int p0, r;
        logic [1:0] d;
        bit found;
        repeat (2) @(negedge clk);
        check("rst_throw", p2Throw, 3'b000);
        check("rst_dense", p2Dense, 2'd3);
        check("rst_valid", throwValid, 1'b0);
        check("rst_round", roundCount, 4'd0);
        check("rst_lfsr", lfsrState, SEED);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("lfsr_seq", lfsrState, lfsr_exp[i]);
        end
        repeat (300) @(negedge clk);
        check("idle_no_valid", npulse, 0);
        // glitch: 3 high, 2 low, 2 high
        playButton = 1'b1;
        repeat (3) @(negedge clk);
        playButton = 1'b0;
        repeat (2) @(negedge clk);
        playButton = 1'b1;
        repeat (2) @(negedge clk);
        playButton = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_no_valid", npulse, 0);
        check("glitch_round", roundCount, 4'd0);
        press(40);
        check("single_pulses", npulse, 1);
        check("single_round", roundCount, 4'd1);
        reset_dut();
        p0 = npulse;
        seen = 3'b000;
        mask = 3'b000;
        for (int i = 0; i < 17; i++) press(12 + i % 3);
        check("wrap_pulses", npulse - p0, 17);
        check("wrap_round", roundCount, 4'd1);
        check("wrap_values", seen, mask);
        check("wrap_all_three", mask, 3'b111);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            predict(m_lfsr, r, d);
            found = (r == 1);
        end
        check("retry_found", found, 1'b1);
        press(12);
        check("retry_round", roundCount, 4'd2);
        expect_throw();
        playButton = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("pre_reset_throw", sb.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_throw", p2Throw, 3'b000);
        check("async_dense", p2Dense, 2'd3);
        check("async_round", roundCount, 4'd0);
        check("async_lfsr", lfsrState, SEED);
        exp_round = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        p0 = npulse;
        expect_throw();
        repeat (30) @(negedge clk);
        playButton = 1'b0;
        repeat (N + 8) @(negedge clk);
        check("post_reset_arrived", sb.size(), 0);
        check("post_reset_pulses", npulse - p0, 1);
        check("post_reset_round", roundCount, 4'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rps_throw_gen.md
# rps_throw_gen

Automated second player for the rock-paper-scissors lab. It debounces the play button and draws a pseudo-random throw from a free-running 8-bit LFSR, rejecting the unused code. It presents the throw in one-hot form, matching the throw inputs the game module consumes, and in dense form. It holds the throw until the button is released and counts rounds, so the game board runs with one human player against the FPGA.

## Interface
Clock is `clk`; reset is `reset`, asynchronous and active-high.

Parameters:
- `LFSR_SEED`, default 8'hA5: LFSR reset value. Must be nonzero; a value of 0 is replaced by 8'h01.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples needed to change the debounced button level. Must be at least 2.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; forces every register to its reset value.
- `playButton`, in, 1: raw, asynchronous push-button, active-high.
- `p2Throw`, out, 3: one-hot throw. 3'b001 is rock, 3'b010 is paper, 3'b100 is scissors, 3'b000 is no throw.
- `p2Dense`, out, 2: dense throw. 0 is rock, 1 is paper, 2 is scissors, 3 is no throw.
- `throwValid`, out, 1: one-cycle pulse when a new throw appears on `p2Throw` and `p2Dense`.
- `roundCount`, out, 4: number of throws made, modulo 16.
- `lfsrState`, out, 8: current LFSR contents, for verification.

## Operation
- **LFSR:** Fibonacci form. Next state is {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances on every clock in every state and never reaches 0.
- **Synchronizer:** two flops, `sync1` then `sync2`, both reset to 0.
- **Debouncer:**
  - `dbLevel` resets to 0 and `dbCount` resets to 0.
  - When `sync2` equals `dbLevel`, `dbCount` is cleared to 0.
  - Otherwise, if `dbCount` equals DEBOUNCE_CYCLES-1, then `dbLevel` takes `sync2` and `dbCount` clears; else `dbCount` increments.
  - `dbRise` = `dbLevel` & ~`dbLevelPrev`, where `dbLevelPrev` is a register that resets to 0.
- **FSM:**
  - IDLE (reset state): on `dbRise`, go to DRAW.
  - DRAW: sample lfsr[1:0].
    - Value 3: stay in DRAW and retry next cycle.
    - Values 0, 1, 2: register the dense throw and its one-hot decode, increment `roundCount` (15 wraps to 0), pulse `throwValid`, and go to SHOW.
  - SHOW: the throw is held. When `dbLevel` is 0, go to IDLE; the throw stays on the outputs.
- **Output persistence:** outputs keep the last throw until the next accepted draw. Only reset returns them to "no throw".
- **Button release during DRAW:** the draw still completes. The FSM then passes through SHOW and drops to IDLE on the next cycle.

## Timing
- Reset values:
  - `p2Throw` = 3'b000, `p2Dense` = 2'd3, `throwValid` = 0, `roundCount` = 0.
  - `lfsrState` = LFSR_SEED, with a seed of 0 mapped to 8'h01.
  - FSM = IDLE.
- **Latency:** let edge 0 be the first edge that samples `playButton` high.
  - `dbLevel` rises after edge 1+DEBOUNCE_CYCLES.
  - The FSM enters DRAW at edge 2+DEBOUNCE_CYCLES.
  - The throw registers, and `throwValid` is high for one cycle, after edge 3+DEBOUNCE_CYCLES.
  - Each rejected sample (lfsr[1:0]==3) adds one cycle.
- **Registered outputs:** `throwValid`, `p2Throw`, `p2Dense` and `roundCount` all change on the same edge.
- **Glitches:** a button glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no `dbLevel` change and no throw.
- **One throw per press:** a held button produces exactly one throw. Another throw requires a debounced release (back to IDLE) and then a new debounced press.
- **Reset during DRAW or SHOW:** state and outputs return to reset values immediately, without waiting for a clock. With the button still held, a new throw follows the full latency above after reset deasserts.

## Test plan
- **LFSR sequence:** release reset with the default seed and button low. `lfsrState` reads A5, 4A, 95, 2A on consecutive cycles, and no `throwValid` occurs for 300 cycles.
- **Single press:** with DEBOUNCE_CYCLES=4, hold the button 40 cycles from edge 0.
  - `throwValid` is high for exactly one cycle, after edge 7 or later (exactly edge 7 if no rejection).
  - `p2Dense` equals the bench model's lfsr[1:0] and is never 3.
  - `p2Throw` is its one-hot decode, and `roundCount` is 1.
- **Glitch rejection:** with DEBOUNCE_CYCLES=4, pulse the button high for 3 cycles, low for 2, then high for 2. There is no `throwValid` and `roundCount` stays 0.
- **Round wrap:** 17 debounced presses, each separated by a debounced release. There are exactly 17 pulses; `roundCount` goes 1..15, 0, 1; every `p2Throw` is one-hot; all three throw values appear.
- **Rejection retry:** choose a seed such that lfsr[1:0]==3 on the DRAW cycle. The FSM stays in DRAW one extra cycle, `throwValid` is delayed by 1, and the throw taken is the next LFSR value.
- **Reset mid-press:** assert `reset` asynchronously mid-cycle while in SHOW.
  - `p2Throw` goes to 000, `p2Dense` to 3, and `roundCount` to 0 before the next clock edge.
  - With the button held through reset, exactly one new throw occurs after the full latency.
